// File: rtl/data_mem.sv
// Word-addressed data memory: combinational read, rising-edge write, and an
// asynchronous active-low reset that clears every word.
module data_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 22,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  writeEnable,
  output logic [DATA_WIDTH-1:0] dataOut
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [1:0]            r_rst_sync;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_range;
  logic                  w_write;

  assign w_idx = address[IDX_W-1:0];

  // DEPTH is a power of two, so in-range means every bit above the index is zero.
  generate
    if (ADDR_WIDTH > IDX_W) begin : g_range
      assign w_in_range = ~|address[ADDR_WIDTH-1:IDX_W];
    end else begin : g_full
      assign w_in_range = 1'b1;
    end
  endgenerate

  // Reset is asserted asynchronously but released through two flops, so the
  // first write after release waits until the release has reached clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_write = writeEnable && w_in_range && r_rst_sync[1];

  // NOTE: this array is built from flops rather than a RAM macro, because
  // every word must clear asynchronously; a RAM block has no such reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem <= '{default: '0};
    end else if (w_write) begin
      r_mem[w_idx] <= dataIn;
    end
  end

  assign dataOut = w_in_range ? r_mem[w_idx] : '0;

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: expected read values are queued as stimulus is
// driven and popped when the combinational read output is sampled.
`timescale 1ns/1ps
module tb_data_mem;

  localparam int DW    = 32;
  localparam int AW    = 22;
  localparam int DEPTH = 1024;

  logic          clk;
  logic          reset;
  logic [AW-1:0] address;
  logic [DW-1:0] dataIn;
  logic          writeEnable;
  logic [DW-1:0] dataOut;

  logic [DW-1:0] exp_q [$];
  string         tag_q [$];
  int            checks;
  int            errors;

  data_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .dataIn      (dataIn),
    .writeEnable (writeEnable),
    .dataOut     (dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input logic [DW-1:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic check();
    logic [DW-1:0] exp;
    string         tag;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h expected <queued value>", dataOut);
    end else begin
      exp = exp_q.pop_front();
      tag = tag_q.pop_front();
      assert (dataOut === exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, dataOut, exp);
      end
    end
  endtask

  task automatic expect_at(input logic [AW-1:0] addr, input logic [DW-1:0] exp,
                           input string tag);
    address = addr;
    push_exp(exp, tag);
    #1;
    check();
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    address     = addr;
    dataIn      = data;
    writeEnable = 1'b1;
    @(posedge clk);
    #1;
    writeEnable = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    address     = '0;
    dataIn      = '0;
    writeEnable = 1'b0;

    // Held in reset: reads are zero and a write is blocked.
    repeat (2) @(posedge clk);
    #2;
    expect_at(22'd0, 32'h0, "in_reset_addr0");
    do_write(22'd3, 32'h1111_2222);
    expect_at(22'd3, 32'h0, "in_reset_write_blocked");

    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_at(22'd0,         32'h0, "post_reset_addr0");
    expect_at(22'd1,         32'h0, "post_reset_addr1");
    expect_at(22'(DEPTH-1),  32'h0, "post_reset_last");

    do_write(22'd0, 32'h1);
    expect_at(22'd0, 32'h1, "write_addr0");
    expect_at(22'd1, 32'h0, "addr1_untouched");

    do_write(22'd5, 32'hDEAD_BEEF);
    do_write(22'd5, 32'h1234_5678);
    expect_at(22'd5, 32'h1234_5678, "overwrite_addr5");

    // Same-address read during write: old word before the edge, new after.
    @(negedge clk);
    address     = 22'd5;
    dataIn      = 32'hCAFE_F00D;
    writeEnable = 1'b1;
    expect_at(22'd5, 32'h1234_5678, "rdw_before_edge");
    @(posedge clk);
    #1;
    writeEnable = 1'b0;
    expect_at(22'd5, 32'hCAFE_F00D, "rdw_after_edge");

    do_write(22'(DEPTH-1), 32'hA5A5_A5A5);
    expect_at(22'(DEPTH-1), 32'hA5A5_A5A5, "write_last");
    expect_at(22'd0,        32'h1,         "addr0_after_last");

    do_write(22'(DEPTH), 32'hFFFF_FFFF);
    expect_at(22'(DEPTH), 32'h0, "oor_depth_reads_zero");
    expect_at(22'd0,      32'h1, "addr0_after_oor");
    do_write(22'h3F_FFFF, 32'h7777_7777);
    expect_at(22'h3F_FFFF, 32'h0,          "oor_top_reads_zero");
    expect_at(22'h3F_FFFF & 22'(DEPTH-1), 32'hA5A5_A5A5, "oor_no_alias");

    // writeEnable pulsed and dataIn changed between edges: storage unchanged.
    @(negedge clk);
    address     = 22'd0;
    dataIn      = 32'h55;
    writeEnable = 1'b1;
    #1 writeEnable = 1'b0;
    #1 dataIn = 32'h66;
    @(posedge clk);
    #1;
    expect_at(22'd0, 32'h1, "glitch_ignored");

    // 1 ns reset pulse mid-cycle, no clock edge inside it.
    @(posedge clk);
    #2;
    address = 22'd0;
    push_exp(32'h0, "async_clear_immediate");
    reset = 1'b0;
    #0.5;
    check();
    #0.5;
    reset = 1'b1;
    expect_at(22'd0, 32'h0, "after_pulse_addr0");
    expect_at(22'd5, 32'h0, "after_pulse_addr5");

    // Write while reset is held low, then the same write after release.
    @(posedge clk);
    #2;
    reset = 1'b0;
    do_write(22'd0, 32'h0000_0077);
    expect_at(22'd0, 32'h0, "write_under_reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    do_write(22'd0, 32'h0000_0077);
    expect_at(22'd0, 32'h0000_0077, "write_after_release");
    expect_at(22'd1, 32'h0,         "addr1_after_release");

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 22, address bus width in bits.
REQ-003 Parameter DEPTH, default 1024, number of implemented words (power of two, at most 2**ADDR_WIDTH).
REQ-004 Port clk, input, 1 bit, single clock; all writes occur on its rising edge.
REQ-005 Port reset, input, 1 bit, asynchronous active-low reset.
REQ-006 Port address, input, ADDR_WIDTH bits, word address for both read and write.
REQ-007 Port dataIn, input, DATA_WIDTH bits, write data.
REQ-008 Port writeEnable, input, 1 bit, active-high write strobe.
REQ-009 Port dataOut, output, DATA_WIDTH bits, read data.
REQ-010 The block SHALL have one clock and one reset; reset is asynchronous and active-low.

Function
REQ-011 Storage SHALL be DEPTH words of DATA_WIDTH bits, word-addressed (no byte enables).
REQ-012 Write: on rising clk with reset high and writeEnable=1, the word at address SHALL take dataIn.
REQ-013 Write with writeEnable=0 SHALL leave storage unchanged.
REQ-014 Read SHALL be combinational: dataOut = word at address, updated within the same cycle as any address change; zero read latency.
REQ-015 Read-during-write, same address: before the edge dataOut SHALL show the old word; after the edge it SHALL show the newly written word, with no extra cycle.
REQ-016 In-range means address < DEPTH; only in-range words are implemented.
REQ-017 Out-of-range writes SHALL be ignored.
REQ-018 Out-of-range reads SHALL return all zeros.
REQ-019 Addresses SHALL NOT wrap; DEPTH-1 is the last valid word, and DEPTH is out of range.
REQ-020 dataIn and writeEnable changing between clock edges SHALL have no effect on storage; only values sampled at the rising edge matter.
REQ-021 X/Z on writeEnable is not supported; the bench SHALL drive it to 0 or 1 at all times.

Reset
REQ-022 Assertion of reset (low) SHALL immediately and asynchronously clear every word to 0, independent of clk.
REQ-023 While reset is low, dataOut SHALL read 0 for every address.
REQ-024 While reset is low, writes SHALL be blocked; reset dominates writeEnable.
REQ-025 Reset assertion in the same cycle as a write SHALL leave the word at 0.
REQ-026 Deassertion of reset SHALL be synchronized internally to clk.
REQ-027 The first write SHALL be honored no earlier than the first rising edge after deassertion.
REQ-028 No other state exists; the block has no power-on initialization beyond reset.

Verification
REQ-029 Reset, then read addresses 0, 1 and DEPTH-1 -> dataOut=0 for each.
REQ-030 address=0, dataIn=1, writeEnable=1, one rising edge; then writeEnable=0 -> dataOut=1 at address 0, and address 1 still reads 0.
REQ-031 Write 0xDEADBEEF to 5, then 0x12345678 to 5 on the next edge -> address 5 reads 0x12345678; write 0xA5A5A5A5 to DEPTH-1 -> reads back, and address 0 is unchanged.
REQ-032 Write 0xFFFFFFFF to address DEPTH -> dataOut=0 at DEPTH, and address 0 is unchanged.
REQ-033 After writing 1 to address 0, pulse reset low for 1 ns mid-cycle without a clock edge -> dataOut=0 immediately.
REQ-034 After the REQ-033 reset, a write to address 0 while reset is held low -> still 0; the same write two edges after release -> the written value.
